// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: status encoding, default watch addresses and state helpers shared by the test monitor.
package test_monitor_pkg;

   typedef enum logic [2:0] {
      ST_ARM,
      ST_RUN,
      ST_PASS,
      ST_FAIL,
      ST_TIMEOUT,
      ST_HANG
   } status_e;

   localparam logic [31:0] DEF_PASS_ADDR   = 32'h0000_0698;
   localparam logic [31:0] DEF_FAIL_ADDR   = 32'h0000_0684;
   localparam logic [31:0] DEF_TOHOST_ADDR = 32'h0000_1000;

   // Any state the monitor can never leave until reset.
   function automatic logic is_terminal(status_e s);
      return s inside {ST_PASS, ST_FAIL, ST_TIMEOUT, ST_HANG};
   endfunction

   // Terminal states that count as a failed run.
   function automatic logic is_failure(status_e s);
      return s inside {ST_FAIL, ST_TIMEOUT, ST_HANG};
   endfunction

endpackage

// File: rtl/test_monitor_if.sv
// test_monitor_if: CPU fetch address and data-write bus as seen by the test monitor.
interface test_monitor_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] iaddr;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] wdata;

   modport master (output iaddr, wr, addr, wdata);
   modport slave  (input  iaddr, wr, addr, wdata);
endinterface

// File: rtl/test_monitor_stall_detector.sv
// stall_detector: counts consecutive clocks with an unchanged fetch address and flags a hang.
module stall_detector #(
   parameter int                ADDR_W      = 32,
   parameter int                HANG_CYCLES = 32,
   parameter logic [ADDR_W-1:0] PASS_ADDR   = '0,
   parameter logic [ADDR_W-1:0] FAIL_ADDR   = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] iaddr,
   output logic              hang_hit
);
   localparam int HW = $clog2(HANG_CYCLES + 1);

   logic [ADDR_W-1:0] prev;
   logic [HW-1:0]     hang_cnt;
   logic              same;

   // PASS/FAIL fetches never count as stalling; they terminate the run instead.
   assign same     = (iaddr == prev) && (iaddr != PASS_ADDR) && (iaddr != FAIL_ADDR);
   assign hang_hit = en && same && (hang_cnt == HW'(HANG_CYCLES - 1));

   // prev tracks iaddr every clock (including ARM) so the first RUN compare is meaningful.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev     <= '0;
         hang_cnt <= '0;
      end else begin
         prev     <= iaddr;
         hang_cnt <= (!en || !same) ? '0 :
                     (hang_cnt == HW'(HANG_CYCLES)) ? hang_cnt : hang_cnt + HW'(1);
      end
   end
endmodule

// File: rtl/test_monitor.sv
// test_monitor: pass/fail/timeout/hang monitor for CPU bring-up; optional tohost mailbox via TEST_MONITOR_TOHOST_EN.
module test_monitor
   import test_monitor_pkg::*;
#(
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] PASS_ADDR      = ADDR_W'(DEF_PASS_ADDR),
   parameter logic [ADDR_W-1:0] FAIL_ADDR      = ADDR_W'(DEF_FAIL_ADDR),
   parameter int                ARM_CYCLES     = 2,
   parameter int                TIMEOUT_CYCLES = 600,
   parameter int                HANG_CYCLES    = 32,
   parameter logic [ADDR_W-1:0] TOHOST_ADDR    = ADDR_W'(DEF_TOHOST_ADDR),
   parameter int                CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   test_monitor_if.slave     bus,
   output logic              done,
   output logic              passed,
   output logic              failed,
   output status_e           status,
   output logic [CNT_W-1:0]  cycles,
   output logic [ADDR_W-1:0] term_addr,
   output logic [ADDR_W-1:0] fail_code
);
   localparam int AW = $clog2(ARM_CYCLES + 1);

   status_e           state, state_nx;
   logic [AW-1:0]     arm_cnt;
   logic [ADDR_W-1:0] term_nx, code_nx;
   logic              hang_hit, th_pass, th_fail;

   assign status = state;

`ifdef TEST_MONITOR_TOHOST_EN
   logic th_hit;
   // Only odd values written to the mailbox end the test; even ones are progress noise.
   assign th_hit  = bus.wr && (bus.addr == TOHOST_ADDR) && bus.wdata[0];
   assign th_pass = th_hit && (bus.wdata == ADDR_W'(1));
   assign th_fail = th_hit && !th_pass;
`else
   logic unused;
   assign unused  = ^{bus.wr, bus.addr, bus.wdata, TOHOST_ADDR};
   assign th_pass = 1'b0;
   assign th_fail = 1'b0;
`endif

   stall_detector #(
      .ADDR_W      (ADDR_W),
      .HANG_CYCLES (HANG_CYCLES),
      .PASS_ADDR   (PASS_ADDR),
      .FAIL_ADDR   (FAIL_ADDR)
   ) u_stall (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (state == ST_RUN),
      .iaddr    (bus.iaddr),
      .hang_hit (hang_hit)
   );

   // Next state and capture values; RUN checks in priority tohost > FAIL > PASS > HANG > TIMEOUT.
   always_comb begin
      state_nx = state;
      term_nx  = term_addr;
      code_nx  = fail_code;
      if (state == ST_ARM) begin
         state_nx = (arm_cnt == AW'(ARM_CYCLES - 1)) ? ST_RUN : ST_ARM;
      end else if (state == ST_RUN) begin
         if (th_fail) begin
            state_nx = ST_FAIL;
            term_nx  = bus.addr;
            code_nx  = bus.wdata >> 1;
         end else if (th_pass) begin
            state_nx = ST_PASS;
            term_nx  = bus.addr;
         end else if (bus.iaddr == FAIL_ADDR) begin
            state_nx = ST_FAIL;
            term_nx  = bus.iaddr;
         end else if (bus.iaddr == PASS_ADDR) begin
            state_nx = ST_PASS;
            term_nx  = bus.iaddr;
         end else if (hang_hit) begin
            state_nx = ST_HANG;
            term_nx  = bus.iaddr;
         end else if (cycles == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_nx = ST_TIMEOUT;
            term_nx  = bus.iaddr;
         end
      end
   end

   // State and result registers; flags are decoded from the next state so they are true flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_ARM;
         term_addr <= '0;
         fail_code <= '0;
         done      <= 1'b0;
         passed    <= 1'b0;
         failed    <= 1'b0;
      end else begin
         state     <= state_nx;
         term_addr <= term_nx;
         fail_code <= code_nx;
         done      <= is_terminal(state_nx);
         passed    <= (state_nx == ST_PASS);
         failed    <= is_failure(state_nx);
      end
   end

   // Arm delay counter and RUN-clock counter; cycles freezes once RUN is left.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         arm_cnt <= '0;
         cycles  <= '0;
      end else begin
         if (state == ST_ARM && arm_cnt != AW'(ARM_CYCLES - 1))
            arm_cnt <= arm_cnt + AW'(1);
         if (state == ST_RUN && cycles != CNT_W'(TIMEOUT_CYCLES))
            cycles <= cycles + CNT_W'(1);
      end
   end
endmodule
